// File: rtl/attn_pkg.sv
// Shared defaults and FSM state encoding for the SRAM transpose engine.
package attn_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 16;
    localparam int unsigned DATA_W_DEFAULT = 32;
    localparam int unsigned DIM_W          = 16;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain
    } state_e;

endpackage

// File: rtl/transpose_addr_gen.sv
// Row/column walk over the source matrix with incremental source and
// transposed destination pointers; no multipliers, everything wraps.
module transpose_addr_gen
    import attn_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [DIM_W-1:0]  num_rows_i,
    input  logic [DIM_W-1:0]  num_cols_i,
    input  logic [ADDR_W-1:0] src_base_i,
    input  logic [ADDR_W-1:0] dst_base_i,
    output logic [ADDR_W-1:0] src_addr_o,
    output logic [ADDR_W-1:0] dst_addr_o,
    output logic              last_o
);

    logic [DIM_W-1:0]  rows_q, rows_d, cols_q, cols_d;
    logic [DIM_W-1:0]  row_q, row_d, col_q, col_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [ADDR_W-1:0] row_dst_q, row_dst_d;
    logic              row_end;

    assign row_end    = (col_q == cols_q - DIM_W'(1));
    assign last_o     = row_end && (row_q == rows_q - DIM_W'(1));
    assign src_addr_o = src_q;
    assign dst_addr_o = dst_q;

    always_comb begin
        rows_d    = rows_q;
        cols_d    = cols_q;
        row_d     = row_q;
        col_d     = col_q;
        src_d     = src_q;
        dst_d     = dst_q;
        row_dst_d = row_dst_q;
        if (load_i) begin
            rows_d    = num_rows_i;
            cols_d    = num_cols_i;
            row_d     = '0;
            col_d     = '0;
            src_d     = src_base_i;
            dst_d     = dst_base_i;
            row_dst_d = dst_base_i;
        end else if (step_i && !last_o) begin
            src_d = src_q + ADDR_W'(1);
            if (row_end) begin
                // Next source row maps to the next destination column start.
                col_d     = '0;
                row_d     = row_q + DIM_W'(1);
                row_dst_d = row_dst_q + ADDR_W'(1);
                dst_d     = row_dst_q + ADDR_W'(1);
            end else begin
                col_d = col_q + DIM_W'(1);
                dst_d = dst_q + ADDR_W'(rows_q);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rows_q    <= '0;
            cols_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            row_dst_q <= '0;
        end else begin
            rows_q    <= rows_d;
            cols_q    <= cols_d;
            row_q     <= row_d;
            col_q     <= col_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            row_dst_q <= row_dst_d;
        end
    end

endmodule

// File: rtl/sram_transpose_engine.sv
// Transposes an R x C matrix between SRAMs: one read per cycle, each read
// becomes a registered write two cycles later.
module sram_transpose_engine
    import attn_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [DIM_W-1:0]  num_rows,
    input  logic [DIM_W-1:0]  num_cols,
    input  logic [ADDR_W-1:0] src_base_address,
    input  logic [ADDR_W-1:0] dst_base_address,
    output logic [ADDR_W-1:0] src_read_address,
    input  logic [DATA_W-1:0] src_read_data,
    output logic              dst_write_enable,
    output logic [ADDR_W-1:0] dst_write_address,
    output logic [DATA_W-1:0] dst_write_data,
    output logic              done
);

    state_e            state_q, state_d;
    logic              done_q, done_d;
    logic              rd_vld_q;
    logic [ADDR_W-1:0] rd_dst_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              nonzero, load, step, last;
    logic [ADDR_W-1:0] dst_addr;

    assign nonzero = (|num_rows) && (|num_cols);
    assign step    = (state_q == StRead);

    transpose_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk_i      (clk),
        .rst_ni     (reset_n),
        .load_i     (load),
        .step_i     (step),
        .num_rows_i (num_rows),
        .num_cols_i (num_cols),
        .src_base_i (src_base_address),
        .dst_base_i (dst_base_address),
        .src_addr_o (src_read_address),
        .dst_addr_o (dst_addr),
        .last_o     (last)
    );

    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        start_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    load    = nonzero;
                    state_d = nonzero ? StRead : StDrain;
                end
            end
            StRead:  if (last) state_d = StDrain;
            // Empty once the final read has left the first stage; its write
            // is already on the output this cycle.
            StDrain: if (!rd_vld_q) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        done_d = (state_q == StDrain) && (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            done_q   <= 1'b0;
            rd_vld_q <= 1'b0;
            rd_dst_q <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            rd_vld_q <= step;
            we_q     <= rd_vld_q;
            if (step) rd_dst_q <= dst_addr;
            if (rd_vld_q) begin
                waddr_q <= rd_dst_q;
                wdata_q <= src_read_data;
            end
        end
    end

    assign dst_write_enable  = we_q;
    assign dst_write_address = waddr_q;
    assign dst_write_data    = wdata_q;
    assign done              = done_q;

endmodule

// File: tb/tb_sram_transpose_engine.sv
// Directed bench for sram_transpose_engine with behavioural source/destination SRAMs.
module tb_sram_transpose_engine;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [15:0] num_rows = '0;
    logic [15:0] num_cols = '0;
    logic [15:0] src_base_address = '0;
    logic [15:0] dst_base_address = '0;
    logic [15:0] src_read_address;
    logic [31:0] src_read_data = '0;
    logic        dst_write_enable;
    logic [15:0] dst_write_address;
    logic [31:0] dst_write_data;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    int mk;
    bit logging = 1'b0;

    logic [31:0] src_mem [65536];
    logic [31:0] dst_mem [65536];

    logic [15:0] wr_addr [$];
    logic [31:0] wr_data [$];
    int          wr_cyc  [$];
    int          done_cyc[$];
    logic [15:0] rd_log [32];
    logic        sr_log [32];

    logic [15:0] t1_addr [6] = '{16'h0100, 16'h0102, 16'h0104, 16'h0101, 16'h0103, 16'h0105};
    logic [31:0] t1_mem  [6] = '{32'd1, 32'd4, 32'd2, 32'd5, 32'd3, 32'd6};
    logic [15:0] t4_rd   [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    logic [15:0] t4_wa   [4] = '{16'hFFFF, 16'h0001, 16'h0000, 16'h0002};
    logic [31:0] t4_wd   [4] = '{32'hA, 32'hB, 32'hC, 32'hD};

    sram_transpose_engine #(
        .ADDR_W (16),
        .DATA_W (32)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start_valid       (start_valid),
        .start_ready       (start_ready),
        .num_rows          (num_rows),
        .num_cols          (num_cols),
        .src_base_address  (src_base_address),
        .dst_base_address  (dst_base_address),
        .src_read_address  (src_read_address),
        .src_read_data     (src_read_data),
        .dst_write_enable  (dst_write_enable),
        .dst_write_address (dst_write_address),
        .dst_write_data    (dst_write_data),
        .done              (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        src_read_data <= src_mem[src_read_address];
        if (dst_write_enable) dst_mem[dst_write_address] <= dst_write_data;
    end

    // Cycle k of a job is the period after accept edge k-1.
    always @(negedge clk) begin
        if (logging) begin
            mk = cyc - t0 + 1;
            if (dst_write_enable) begin
                wr_addr.push_back(dst_write_address);
                wr_data.push_back(dst_write_data);
                wr_cyc.push_back(mk);
            end
            if (done) done_cyc.push_back(mk);
            if (mk >= 0 && mk < 32) begin
                rd_log[mk[4:0]] = src_read_address;
                sr_log[mk[4:0]] = start_ready;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cyc.delete();
        t0 = cyc;
        logging = 1'b1;
    endtask

    task automatic start_job(input logic [15:0] r, input logic [15:0] c,
                             input logic [15:0] sa, input logic [15:0] da);
        @(negedge clk);
        num_rows = r;
        num_cols = c;
        src_base_address = sa;
        dst_base_address = da;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        clear_logs();
    endtask

    task automatic wait_done(input int bound, input string tag);
        int n = 0;
        while (done_cyc.size() == 0 && n < bound) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({tag, "_done_seen"}, 64'(done_cyc.size() != 0), 64'd1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            src_mem[i] = '0;
            dst_mem[i] = '0;
        end
        for (int i = 0; i < 6; i++) src_mem[16'h0010 + i] = 32'(i + 1);
        src_mem[16'h0005] = 32'hDEADBEEF;
        src_mem[16'hFFFE] = 32'hA;
        src_mem[16'hFFFF] = 32'hB;
        src_mem[16'h0000] = 32'hC;
        src_mem[16'h0001] = 32'hD;
        for (int i = 0; i < 16; i++) src_mem[16'h0200 + i] = 32'h1000 + 32'(i);

        // Reset values
        #2 reset_n = 1'b0;
        #1;
        chk("rst_ready", 64'(start_ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_we", 64'(dst_write_enable), 64'd0);
        chk("rst_waddr", 64'(dst_write_address), 64'd0);
        chk("rst_wdata", 64'(dst_write_data), 64'd0);
        chk("rst_raddr", 64'(src_read_address), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // 2x3 transpose
        start_job(16'd2, 16'd3, 16'h0010, 16'h0100);
        wait_done(30, "t1");
        chk("t1_wr_count", 64'(wr_addr.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < wr_addr.size()) begin
                chk("t1_wr_addr", 64'(wr_addr[i]), 64'(t1_addr[i]));
                chk("t1_wr_cyc", 64'(wr_cyc[i]), 64'(3 + i));
            end
            chk("t1_dst_mem", 64'(dst_mem[16'h0100 + i]), 64'(t1_mem[i]));
        end
        chk("t1_done_count", 64'(done_cyc.size()), 64'd1);
        if (done_cyc.size() > 0) chk("t1_done_cyc", 64'(done_cyc[0]), 64'd9);
        chk("t1_ready_c1", 64'(sr_log[1]), 64'd0);
        chk("t1_ready_c8", 64'(sr_log[8]), 64'd0);
        chk("t1_ready_c9", 64'(sr_log[9]), 64'd1);
        chk("t1_rd_c1", 64'(rd_log[1]), 64'h0010);
        chk("t1_rd_c6", 64'(rd_log[6]), 64'h0015);

        // 1x1
        start_job(16'd1, 16'd1, 16'h0005, 16'h0009);
        wait_done(20, "t2");
        chk("t2_wr_count", 64'(wr_addr.size()), 64'd1);
        if (wr_addr.size() > 0) begin
            chk("t2_wr_addr", 64'(wr_addr[0]), 64'h0009);
            chk("t2_wr_data", 64'(wr_data[0]), 64'hDEADBEEF);
            chk("t2_wr_cyc", 64'(wr_cyc[0]), 64'd3);
        end
        if (done_cyc.size() > 0) chk("t2_done_cyc", 64'(done_cyc[0]), 64'd4);

        // Zero rows
        start_job(16'd0, 16'd4, 16'h0020, 16'h0040);
        wait_done(20, "t3");
        chk("t3_wr_count", 64'(wr_addr.size()), 64'd0);
        chk("t3_done_count", 64'(done_cyc.size()), 64'd1);
        if (done_cyc.size() > 0) chk("t3_done_cyc", 64'(done_cyc[0]), 64'd2);
        chk("t3_ready_c1", 64'(sr_log[1]), 64'd0);
        chk("t3_ready_c2", 64'(sr_log[2]), 64'd1);
        chk("t3_raddr_hold", 64'(rd_log[1]), 64'h0005);

        // Address wrap
        start_job(16'd2, 16'd2, 16'hFFFE, 16'hFFFF);
        wait_done(20, "t4");
        for (int i = 0; i < 4; i++) chk("t4_rd_addr", 64'(rd_log[i + 1]), 64'(t4_rd[i]));
        chk("t4_wr_count", 64'(wr_addr.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < wr_addr.size()) begin
                chk("t4_wr_addr", 64'(wr_addr[i]), 64'(t4_wa[i]));
                chk("t4_wr_data", 64'(wr_data[i]), 64'(t4_wd[i]));
            end
        end

        // 4x4 with an ignored start in cycle 5
        start_job(16'd4, 16'd4, 16'h0200, 16'h0300);
        repeat (4) @(posedge clk);
        #1;
        num_rows = 16'd1;
        num_cols = 16'd1;
        src_base_address = 16'h0005;
        dst_base_address = 16'h0777;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        wait_done(40, "t5");
        repeat (6) @(posedge clk);
        #1;
        chk("t5_wr_count", 64'(wr_addr.size()), 64'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < wr_addr.size()) begin
                chk("t5_wr_addr", 64'(wr_addr[i]), 64'(16'h0300 + 16'((i % 4) * 4 + i / 4)));
                chk("t5_wr_data", 64'(wr_data[i]), 64'(32'h1000 + 32'(i)));
                chk("t5_wr_cyc", 64'(wr_cyc[i]), 64'(3 + i));
            end
        end
        chk("t5_done_count", 64'(done_cyc.size()), 64'd1);
        if (done_cyc.size() > 0) chk("t5_done_cyc", 64'(done_cyc[0]), 64'd19);
        chk("t5_no_write_777", 64'(dst_mem[16'h0777]), 64'd0);

        // Reset mid-job, then a fresh job
        start_job(16'd3, 16'd3, 16'h0010, 16'h0500);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_ready", 64'(start_ready), 64'd1);
        chk("t6_rst_done", 64'(done), 64'd0);
        chk("t6_rst_we", 64'(dst_write_enable), 64'd0);
        chk("t6_rst_waddr", 64'(dst_write_address), 64'd0);
        chk("t6_rst_wdata", 64'(dst_write_data), 64'd0);
        chk("t6_rst_raddr", 64'(src_read_address), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        clear_logs();
        repeat (10) @(posedge clk);
        #1;
        chk("t6_no_writes", 64'(wr_addr.size()), 64'd0);
        chk("t6_no_done", 64'(done_cyc.size()), 64'd0);
        chk("t6_ready", 64'(start_ready), 64'd1);
        start_job(16'd1, 16'd2, 16'h0010, 16'h0400);
        wait_done(20, "t7");
        chk("t7_wr_count", 64'(wr_addr.size()), 64'd2);
        if (wr_addr.size() > 1) begin
            chk("t7_wr0_addr", 64'(wr_addr[0]), 64'h0400);
            chk("t7_wr0_data", 64'(wr_data[0]), 64'd1);
            chk("t7_wr1_addr", 64'(wr_addr[1]), 64'h0401);
            chk("t7_wr1_data", 64'(wr_data[1]), 64'd2);
        end
        if (done_cyc.size() > 0) chk("t7_done_cyc", 64'(done_cyc[0]), 64'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_transpose_engine.md
SRAM_TRANSPOSE_ENGINE -- requirements
Module: sram_transpose_engine

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, SRAM address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, SRAM word width; one matrix element per word.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low; ports are named clk and reset_n.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 start_valid  input  1  job request; sampled only while start_ready=1.
REQ-007 start_ready  output  1  high only in IDLE; low from the cycle after acceptance until the job completes.
REQ-008 num_rows  input  16  source row count R, latched on acceptance.
REQ-009 num_cols  input  16  source column count C, latched on acceptance.
REQ-010 src_base_address  input  ADDR_W  source element (0,0) address, latched on acceptance.
REQ-011 dst_base_address  input  ADDR_W  destination element (0,0) address, latched on acceptance.
REQ-012 src_read_address  output  ADDR_W  source SRAM read address; read data returns next cycle.
REQ-013 src_read_data  input  DATA_W  source SRAM read data.
REQ-014 dst_write_enable  output  1  destination SRAM write strobe, registered.
REQ-015 dst_write_address  output  ADDR_W  destination write address, registered.
REQ-016 dst_write_data  output  DATA_W  destination write data, registered.
REQ-017 done  output  1  one-cycle pulse on the cycle the block returns to IDLE after an accepted job.

Function
REQ-018 The block SHALL copy source element (r,c) at src_base + r*C + c to dst_base + c*R + r for all r<R, c<C.
REQ-019 A job SHALL be accepted on a rising edge where start_valid=1 and start_ready=1; config inputs SHALL be latched on that edge; later changes to them SHALL be ignored.
REQ-020 FSM states SHALL be IDLE, READ, DRAIN: IDLE->READ on acceptance with R>0 and C>0; IDLE->DRAIN on acceptance with R=0 or C=0; READ->DRAIN after issuing the last read; DRAIN->IDLE when the read/write pipeline is empty.
REQ-021 In READ the block SHALL issue exactly one read per cycle in row-major order (c inner, r outer) with no gaps.
REQ-022 Each read issued in cycle t SHALL produce dst_write_enable=1 with its address and data in cycle t+2; writes SHALL appear in read order.
REQ-023 For an R*C=N>0 job accepted at edge 0, reads SHALL occur in cycles 1..N, writes in cycles 3..N+2, done and start_ready=1 in cycle N+3.
REQ-024 For R=0 or C=0, the block SHALL perform no reads or writes, and start_ready SHALL be low for exactly one cycle, with done high in the cycle it returns high.
REQ-025 Address arithmetic SHALL use incremental adders (no multipliers) and wrap modulo 2^ADDR_W.
REQ-026 start_valid while start_ready=0 SHALL be ignored and SHALL not be queued.
REQ-027 Outside write cycles dst_write_enable SHALL be 0; dst_write_address/data SHALL hold their last value.
REQ-028 src_read_address SHALL hold its last value outside READ.

Reset
REQ-029 On reset_n low, asynchronously: state=IDLE, start_ready=1, done=0, dst_write_enable=0, dst_write_address=0, dst_write_data=0, src_read_address=0, pipeline valids cleared.
REQ-030 Reset mid-job SHALL abort the job; no further writes SHALL be issued after reset deasserts until a new job is accepted.

Structure
REQ-031 The shared package attn_pkg SHALL hold the ADDR_W/DATA_W defaults and the FSM state enum.
REQ-032 Row/column counters and source/destination pointer generation SHALL live in one sub-module, transpose_addr_gen; the top holds FSM, 2-stage valid pipeline and write registers.

Verification
REQ-033 R=2, C=3, src_base=0x0010 holding 1..6, dst_base=0x0100 -> dst 0x0100..0x0105 = 1,4,2,5,3,6; writes in cycles 3..8; done in cycle 9.
REQ-034 R=1, C=1, src_base=5 holding 0xDEADBEEF, dst_base=9 -> single write to 9 in cycle 3; done in cycle 4.
REQ-035 R=0, C=4 -> no reads or writes; start_ready low one cycle; done pulses once.
REQ-036 R=2, C=2, src_base=0xFFFE holding A,B,C,D, dst_base=0xFFFF -> reads 0xFFFE,0xFFFF,0x0000,0x0001; writes A->0xFFFF, C->0x0000, B->0x0001, D->0x0002.
REQ-037 R=4, C=4 job, start_valid pulsed with new config in cycle 5 -> ignored; all 16 writes follow the original config; exactly one done.
REQ-038 R=3, C=3 job, reset_n low in cycle 4 -> outputs at reset values; no writes after release; start_ready=1; next job completes correctly.
